hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage CPU (F/D/E/M/W).
- Decides stall, flush and forwarding for every stage from register addresses and control bits the decode logic already produces (RegWrite, MemToReg, branch).
- Holds the pipeline across a multi-cycle data-memory handshake and keeps a stall performance counter.
- Sits beside the decode control logic. Its outputs drive the pipeline-register enable/clear pins and the Execute operand muxes.

---
 rtl/hazard_controller_if.sv | 44 ++++
 rtl/hazard_controller.sv | 110 +++++++++++
 tb/tb_hazard_controller.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline hazard bundle between datapath/decode and the hazard controller
interface hazard_controller_if #(
    parameter int REG_ADDR_W = 3,
    parameter int PERF_W     = 16
);
    logic [REG_ADDR_W-1:0] i_rs1D;
    logic [REG_ADDR_W-1:0] i_rs2D;
    logic [REG_ADDR_W-1:0] i_rs1E;
    logic [REG_ADDR_W-1:0] i_rs2E;
    logic [REG_ADDR_W-1:0] i_rdE;
    logic                  i_MemToRegE;
    logic [REG_ADDR_W-1:0] i_rdM;
    logic                  i_RegWriteM;
    logic [REG_ADDR_W-1:0] i_rdW;
    logic                  i_RegWriteW;
    logic                  i_branchTakenE;
    logic                  i_memAccessM;
    logic                  i_memReady;
    logic                  o_stallF;
    logic                  o_stallD;
    logic                  o_stallE;
    logic                  o_stallM;
    logic                  o_flushD;
    logic                  o_flushE;
    logic                  o_flushW;
    logic [1:0]            o_fwdAE;
    logic [1:0]            o_fwdBE;
    logic                  o_memTimeout;
    logic [PERF_W-1:0]     o_stallCount;

    modport master (
        output i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_MemToRegE, i_rdM, i_RegWriteM,
               i_rdW, i_RegWriteW, i_branchTakenE, i_memAccessM, i_memReady,
        input  o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_flushW,
               o_fwdAE, o_fwdBE, o_memTimeout, o_stallCount
    );

    modport slave (
        input  i_rs1D, i_rs2D, i_rs1E, i_rs2E, i_rdE, i_MemToRegE, i_rdM, i_RegWriteM,
               i_rdW, i_RegWriteW, i_branchTakenE, i_memAccessM, i_memReady,
        output o_stallF, o_stallD, o_stallE, o_stallM, o_flushD, o_flushE, o_flushW,
               o_fwdAE, o_fwdBE, o_memTimeout, o_stallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward sequencing for the 5-stage pipeline
module hazard_controller #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    hazard_controller_if.slave hz
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  waitCnt, waitCntNext;
    logic              memTimeout;
    logic [PERF_W-1:0] stallCount;

    logic stallAll, stallFD, flushD, flushE, flushW, timeoutHit;
    logic loadUse, memHold;

    // M stage result is younger than W, so it wins when both target the operand
    function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src);
        if (hz.i_RegWriteM && hz.i_rdM == src && src != '0)
            return 2'b10;
        else if (hz.i_RegWriteW && hz.i_rdW == src && src != '0)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign loadUse = hz.i_MemToRegE && hz.i_rdE != '0 &&
                     (hz.i_rdE == hz.i_rs1D || hz.i_rdE == hz.i_rs2D);
    assign memHold = hz.i_memAccessM && !hz.i_memReady;

    always_comb begin
        stallAll    = 1'b0;
        stallFD     = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        timeoutHit  = 1'b0;
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            RUN: begin
                if (memHold) begin
                    stallAll    = 1'b1;
                    flushW      = 1'b1;
                    stateNext   = MEM_WAIT;
                    waitCntNext = CNT_W'(1);
                end else if (hz.i_branchTakenE) begin
                    // Decode holds a wrong-path instruction, so its load-use is moot
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (loadUse) begin
                    stallFD = 1'b1;
                    flushE  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.i_memReady) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else if (waitCnt == CNT_W'(MEM_TIMEOUT)) begin
                    timeoutHit  = 1'b1;
                    stateNext   = RUN;
                    waitCntNext = '0;
                end else begin
                    stallAll    = 1'b1;
                    flushW      = 1'b1;
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= RUN;
            waitCnt    <= '0;
            memTimeout <= 1'b0;
            stallCount <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (timeoutHit)
                memTimeout <= 1'b1;
            if ((stallAll || stallFD) && stallCount != {PERF_W{1'b1}})
                stallCount <= stallCount + PERF_W'(1);
        end
    end

    assign hz.o_stallF     = stallAll | stallFD;
    assign hz.o_stallD     = stallAll | stallFD;
    assign hz.o_stallE     = stallAll;
    assign hz.o_stallM     = stallAll;
    assign hz.o_flushD     = flushD;
    assign hz.o_flushE     = flushE;
    assign hz.o_flushW     = flushW;
    assign hz.o_fwdAE      = fwdSel(hz.i_rs1E);
    assign hz.o_fwdBE      = fwdSel(hz.i_rs2E);
    assign hz.o_memTimeout = memTimeout;
    assign hz.o_stallCount = stallCount;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared = 0;
    int   nFail = 0;

    hazard_controller_if #(.REG_ADDR_W(3), .PERF_W(16)) hif ();

    hazard_controller #(.REG_ADDR_W(3), .MEM_TIMEOUT(15), .PERF_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        hif.i_rs1D = '0; hif.i_rs2D = '0; hif.i_rs1E = '0; hif.i_rs2E = '0;
        hif.i_rdE = '0; hif.i_MemToRegE = 1'b0; hif.i_rdM = '0; hif.i_RegWriteM = 1'b0;
        hif.i_rdW = '0; hif.i_RegWriteW = 1'b0; hif.i_branchTakenE = 1'b0;
        hif.i_memAccessM = 1'b0; hif.i_memReady = 1'b0;
    endtask

    // Packs {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
    function automatic logic [31:0] ctl();
        return {25'd0, hif.o_stallF, hif.o_stallD, hif.o_stallE, hif.o_stallM,
                hif.o_flushD, hif.o_flushE, hif.o_flushW};
    endfunction

    initial begin
        clearInputs();
        #2;
        check("reset_ctl", ctl(), 32'h00);
        check("reset_count", hif.o_stallCount, 32'd0);
        check("reset_timeout", hif.o_memTimeout, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // forwarding
        hif.i_rs1E = 3'd3; hif.i_RegWriteM = 1'b1; hif.i_rdM = 3'd3;
        hif.i_RegWriteW = 1'b1; hif.i_rdW = 3'd0; hif.i_rs2E = 3'd0;
        #1;
        check("fwdA_M_over_W0", hif.o_fwdAE, 32'd2);
        check("fwdB_zero_reg", hif.o_fwdBE, 32'd0);
        hif.i_rdW = 3'd3; hif.i_rs2E = 3'd3;
        #1;
        check("fwdA_M_priority", hif.o_fwdAE, 32'd2);
        hif.i_RegWriteM = 1'b0;
        #1;
        check("fwdA_W_only", hif.o_fwdAE, 32'd1);
        check("fwdB_W_only", hif.o_fwdBE, 32'd1);
        hif.i_RegWriteM = 1'b1; hif.i_rdM = 3'd5; hif.i_RegWriteW = 1'b0;
        #1;
        check("fwdA_none", hif.o_fwdAE, 32'd0);
        check("fwd_no_stall", ctl(), 32'h00);
        clearInputs();

        // load-use
        tick();
        hif.i_MemToRegE = 1'b1; hif.i_rdE = 3'd2; hif.i_rs2D = 3'd2; hif.i_rs1D = 3'd4;
        #1;
        check("loaduse_ctl", ctl(), 32'h62);
        tick();
        clearInputs();
        #1;
        check("after_loaduse_ctl", ctl(), 32'h00);
        check("after_loaduse_count", hif.o_stallCount, 32'd1);
        hif.i_MemToRegE = 1'b1; hif.i_rdE = 3'd0; hif.i_rs1D = 3'd0;
        #1;
        check("loaduse_rd0", ctl(), 32'h00);

        // branch beats load-use
        hif.i_rdE = 3'd2; hif.i_rs1D = 3'd2; hif.i_branchTakenE = 1'b1;
        #1;
        check("branch_over_loaduse", ctl(), 32'h06);
        tick();
        clearInputs();
        check("branch_count", hif.o_stallCount, 32'd1);

        // memory wait of 3 cycles with a branch and load-use present
        tick();
        hif.i_memAccessM = 1'b1; hif.i_branchTakenE = 1'b1;
        hif.i_MemToRegE = 1'b1; hif.i_rdE = 3'd1; hif.i_rs1D = 3'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("memwait_c%0d", c), ctl(), 32'h79);
            tick();
        end
        hif.i_memReady = 1'b1;
        #1;
        check("memready_release", ctl(), 32'h00);
        tick();
        clearInputs();
        #1;
        check("memwait_count", hif.o_stallCount, 32'd4);

        // timeout
        hif.i_memAccessM = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (!(hif.o_stallF && hif.o_stallM && hif.o_flushW))
                check($sformatf("timeout_stall_c%0d", c), ctl(), 32'h79);
            tick();
        end
        #1;
        check("timeout_release", ctl(), 32'h00);
        check("timeout_not_yet", hif.o_memTimeout, 32'd0);
        tick();
        hif.i_memAccessM = 1'b0;
        #1;
        check("timeout_sticky", hif.o_memTimeout, 32'd1);
        check("timeout_count", hif.o_stallCount, 32'd19);
        tick(); tick();
        check("timeout_still_sticky", hif.o_memTimeout, 32'd1);
        check("idle_after_timeout", ctl(), 32'h00);

        // async reset in MEM_WAIT
        hif.i_memAccessM = 1'b1;
        tick(); tick();
        check("pre_reset_wait", ctl(), 32'h79);
        #2;
        rst = 1'b1; hif.i_memAccessM = 1'b0;
        #1;
        check("async_reset_ctl", ctl(), 32'h00);
        check("async_reset_count", hif.o_stallCount, 32'd0);
        check("async_reset_timeout", hif.o_memTimeout, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_reset", ctl(), 32'h00);
        check("idle_after_reset_count", hif.o_stallCount, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end
endmodule
